// File: rtl/traffic_light_controller.sv
// Two-road traffic light controller: six-phase NS/EW cycle with pedestrian
// green shortening, night flashing-yellow mode, 7-segment countdown and 8x8 pictogram.
module traffic_light_controller #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 5_000,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic [7:0] dot_row,
    output logic [7:0] dot_column
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] AR1   = 3'd2;
    localparam logic [2:0] EW_G  = 3'd3;
    localparam logic [2:0] EW_Y  = 3'd4;
    localparam logic [2:0] AR2   = 3'd5;
    localparam logic [2:0] FLASH = 3'd6;

    localparam logic [1:0] GL_GO      = 2'd0;
    localparam logic [1:0] GL_CAUTION = 2'd1;
    localparam logic [1:0] GL_STOP    = 2'd2;
    localparam logic [1:0] GL_BLANK   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic          tick;
    logic          stick;
    logic [2:0]    state;
    logic [2:0]    state_d;
    logic [6:0]    remain;
    logic [6:0]    remain_d;
    logic          ped_pending;
    logic          ped_d;
    logic          blink;
    logic          blink_d;
    logic          do_step;
    logic [2:0]    row_idx;
    logic [1:0]    glyph_sel;
    logic [3:0]    tens_digit;
    logic [3:0]    ones_digit;

    function automatic logic [6:0] dur(input logic [2:0] s);
        case (s)
            NS_G, EW_G: return 7'(GREEN_T);
            NS_Y, EW_Y: return 7'(YELLOW_T);
            default:    return 7'(ALLRED_T);
        endcase
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] s);
        case (s)
            NS_G:    return NS_Y;
            NS_Y:    return AR1;
            AR1:     return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return AR2;
            default: return NS_G;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [7:0] glyph(input logic [1:0] kind, input logic [2:0] r);
        logic [63:0] rom;
        int          idx;
        case (kind)
            GL_GO:      rom = 64'h3030_987E_1918_1412;
            GL_CAUTION: rom = 64'h0024_3CBD_FF3C_3C00;
            GL_STOP:    rom = 64'h1818_3C3C_5A18_1824;
            default:    rom = 64'h0;
        endcase
        idx = 7 - int'(r);
        return rom[idx*8 +: 8];
    endfunction

    assign tick  = (tcnt == TICK_LAST);
    assign stick = (scnt == SCAN_LAST);

    always_comb begin
        state_d  = state;
        remain_d = remain;
        blink_d  = blink;
        ped_d    = ped_pending;
        do_step  = 1'b0;
        if (tick) begin
            if (state == FLASH) begin
                blink_d = ~blink;
                if (!night_mode) begin
                    state_d  = AR1;
                    remain_d = 7'(ALLRED_T);
                end
            end else if ((state == NS_G || state == EW_G) && ped_pending) begin
                ped_d = 1'b0;
                if (remain > 7'(PED_T)) remain_d = 7'(PED_T);
                else                    do_step  = 1'b1;
            end else begin
                do_step = 1'b1;
            end
        end
        if (do_step) begin
            if (remain != 7'd1) begin
                remain_d = remain - 7'd1;
            end else if ((state == AR1 || state == AR2) && night_mode) begin
                state_d  = FLASH;
                blink_d  = 1'b1;
                remain_d = 7'd0;
            end else begin
                state_d  = next_phase(state);
                remain_d = dur(next_phase(state));
            end
        end
        // Code 7 is unreachable in normal operation; force a clean restart.
        if (state == 3'd7) begin
            state_d  = NS_G;
            remain_d = 7'(GREEN_T);
        end
        ped_d = ped_d | ped_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt        <= '0;
            scnt        <= '0;
            state       <= NS_G;
            remain      <= 7'(GREEN_T);
            ped_pending <= 1'b0;
            blink       <= 1'b0;
        end else begin
            tcnt        <= tick  ? '0 : tcnt + 1'b1;
            scnt        <= stick ? '0 : scnt + 1'b1;
            state       <= state_d;
            remain      <= remain_d;
            ped_pending <= ped_d;
            blink       <= blink_d;
        end
    end

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        case (state)
            NS_G:    ns_light = 3'b001;
            NS_Y:    ns_light = 3'b010;
            EW_G:    ew_light = 3'b001;
            EW_Y:    ew_light = 3'b010;
            FLASH: begin
                ns_light = {1'b0, blink, 1'b0};
                ew_light = {1'b0, blink, 1'b0};
            end
            default: ;
        endcase
    end

    assign phase      = state;
    assign tens_digit = 4'(remain / 7'd10);
    assign ones_digit = 4'(remain % 7'd10);
    assign seg_tens   = (state == FLASH || tens_digit == 4'd0) ? SEG_BLANK : seg7(tens_digit);
    assign seg_ones   = (state == FLASH) ? SEG_BLANK : seg7(ones_digit);

    always_comb begin
        case (state)
            NS_G, EW_G: glyph_sel = GL_GO;
            NS_Y, EW_Y: glyph_sel = GL_CAUTION;
            FLASH:      glyph_sel = blink ? GL_CAUTION : GL_BLANK;
            default:    glyph_sel = GL_STOP;
        endcase
    end

    // Dot-matrix row scan: registered, one row per stick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx    <= 3'd0;
            dot_row    <= 8'hFF;
            dot_column <= 8'h00;
        end else if (stick) begin
            row_idx    <= row_idx + 3'd1;
            dot_row    <= ~(8'h80 >> row_idx);
            dot_column <= glyph(glyph_sel, row_idx);
        end
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: a tick-level reference model
// predicts every cycle's outputs; a monitor compares them after each clock edge.
module tb_traffic_light_controller;

    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int GRN = 10;
    localparam int YEL = 3;
    localparam int ALR = 1;
    localparam int PED = 5;

    logic       clk;
    logic       reset;
    logic       night_mode;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [7:0] dot_row;
    logic [7:0] dot_column;

    traffic_light_controller #(
        .TICK_DIV(TD),
        .SCAN_DIV(SD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .night_mode(night_mode),
        .ped_req   (ped_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase),
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones),
        .dot_row   (dot_row),
        .dot_column(dot_column)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic [2:0] ph;
        logic [6:0] st;
        logic [6:0] so;
        logic [7:0] dr;
        logic [7:0] dc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference tables: phase order NS_G, NS_Y, AR1, EW_G, EW_Y, AR2
    int         dur_tab [6] = '{GRN, YEL, ALR, GRN, YEL, ALR};
    logic [2:0] ns_tab  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [7:0] go_g   [8] = '{8'h30, 8'h30, 8'h98, 8'h7E, 8'h19, 8'h18, 8'h14, 8'h12};
    logic [7:0] caut_g [8] = '{8'h00, 8'h24, 8'h3C, 8'hBD, 8'hFF, 8'h3C, 8'h3C, 8'h00};
    logic [7:0] stop_g [8] = '{8'h18, 8'h18, 8'h3C, 8'h3C, 8'h5A, 8'h18, 8'h18, 8'h24};

    int         m_ph, m_rem, m_tcnt, m_scnt, m_row;
    bit         m_ped, m_blink;
    logic [7:0] m_drow, m_dcol;

    function automatic logic [7:0] glyph_of(int ph, bit blk, int r);
        if (ph == 0 || ph == 3) return go_g[r];
        if (ph == 1 || ph == 4) return caut_g[r];
        if (ph == 6)            return blk ? caut_g[r] : 8'h00;
        return stop_g[r];
    endfunction

    task automatic model_reset();
        m_ph = 0; m_rem = GRN; m_tcnt = 0; m_scnt = 0; m_row = 0;
        m_ped = 0; m_blink = 0; m_drow = 8'hFF; m_dcol = 8'h00;
    endtask

    task automatic model_step(input bit night, input bit ped);
        bit tk, stk, adv;
        tk  = (m_tcnt == TD - 1);
        stk = (m_scnt == SD - 1);
        adv = 0;
        if (stk) begin
            m_drow = ~(8'h80 >> m_row);
            m_dcol = glyph_of(m_ph, m_blink, m_row);
            m_row  = (m_row + 1) % 8;
        end
        if (tk) begin
            if (m_ph == 6) begin
                m_blink = !m_blink;
                if (!night) begin m_ph = 2; m_rem = ALR; end
            end else if ((m_ph == 0 || m_ph == 3) && m_ped) begin
                m_ped = 0;
                if (m_rem > PED) m_rem = PED;
                else             adv = 1;
            end else begin
                adv = 1;
            end
            if (adv) begin
                if (m_rem > 1) m_rem = m_rem - 1;
                else if ((m_ph == 2 || m_ph == 5) && night) begin m_ph = 6; m_blink = 1; end
                else begin m_ph = (m_ph + 1) % 6; m_rem = dur_tab[m_ph]; end
            end
        end
        if (ped) m_ped = 1;
        m_tcnt = (m_tcnt + 1) % TD;
        m_scnt = (m_scnt + 1) % SD;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ph = 3'(m_ph);
        e.dr = m_drow;
        e.dc = m_dcol;
        if (m_ph == 6) begin
            e.ns = {1'b0, m_blink, 1'b0};
            e.ew = {1'b0, m_blink, 1'b0};
            e.st = 7'h7F;
            e.so = 7'h7F;
        end else begin
            e.ns = ns_tab[m_ph];
            e.ew = ew_tab[m_ph];
            e.st = (m_rem / 10 == 0) ? 7'h7F : seg_tab[m_rem / 10];
            e.so = seg_tab[m_rem % 10];
        end
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        n_cmp++;
        if (ns_light !== e.ns || ew_light !== e.ew || phase !== e.ph || seg_tens !== e.st ||
            seg_ones !== e.so || dot_row !== e.dr || dot_column !== e.dc) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s t=%0t: got ns=%b ew=%b ph=%0d tens=%b ones=%b row=%h col=%h; want ns=%b ew=%b ph=%0d tens=%b ones=%b row=%h col=%h",
                         name, $time, ns_light, ew_light, phase, seg_tens, seg_ones, dot_row, dot_column,
                         e.ns, e.ew, e.ph, e.st, e.so, e.dr, e.dc);
        end
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic cyc(input bit night, input bit ped);
        @(negedge clk);
        reset      = 1'b0;
        night_mode = night;
        ped_req    = ped;
        model_step(night, ped);
        sbq.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        model_reset();
        #1;
        check_out("async_reset", model_out());
        dchk("reset_dot_row", 32'(dot_row), 32'hFF);
        sbq.push_back(model_out());
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check_out("cycle", e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit night;
        int guard;
        reset = 1'b1; night_mode = 1'b0; ped_req = 1'b0;
        model_reset();
        do_reset();

        // Full cycle: 28 ticks return to NS_G showing 10
        repeat (28 * TD) cyc(0, 0);
        @(posedge clk); #2;
        dchk("cycle_phase", 32'(phase), 0);
        dchk("cycle_tens", 32'(seg_tens), 32'b1111001);
        dchk("cycle_ones", 32'(seg_ones), 32'b1000000);

        // Pedestrian request at remain 9 caps green to 5
        repeat (TD) cyc(0, 0);
        cyc(0, 1);
        repeat (TD - 1) cyc(0, 0);
        @(posedge clk); #2;
        dchk("ped_cap_ones", 32'(seg_ones), 32'b0010010);
        dchk("ped_cap_tens", 32'(seg_tens), 32'h7F);
        repeat (5 * TD) cyc(0, 0);
        @(posedge clk); #2;
        dchk("ped_ns_y", 32'(phase), 1);

        // Late request in EW_G at remain 3 only decrements
        repeat (11 * TD) cyc(0, 0);
        cyc(0, 1);
        repeat (TD - 1) cyc(0, 0);
        @(posedge clk); #2;
        dchk("late_phase", 32'(phase), 3);
        dchk("late_ones", 32'(seg_ones), 32'b0100100);
        dchk("late_pending", 32'(dut.ped_pending), 0);

        // Night mode: finish the cycle, flash, then resume via AR1
        guard = 0;
        do begin cyc(1, 0); guard++; end while (m_ph != 6 && guard < 200);
        dchk("flash_reached", 32'(guard < 200), 1);
        repeat (4 * TD) cyc(1, 0);
        @(posedge clk); #2;
        dchk("flash_phase", 32'(phase), 6);
        dchk("flash_ones", 32'(seg_ones), 32'h7F);
        guard = 0;
        do begin cyc(0, 0); guard++; end while (m_ph != 3 && guard < 40);
        @(posedge clk); #2;
        dchk("resume_phase", 32'(phase), 3);
        dchk("resume_tens", 32'(seg_tens), 32'b1111001);
        dchk("resume_ones", 32'(seg_ones), 32'b1000000);

        // Reset while flashing
        guard = 0;
        do begin cyc(1, 1); guard++; end while (m_ph != 6 && guard < 200);
        repeat (5) cyc(1, 0);
        do_reset();
        dchk("rst_flash_phase", 32'(phase), 0);
        dchk("rst_flash_col", 32'(dot_column), 0);

        // Randomized traffic
        night = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(59) == 0) night = !night;
            if ($urandom_range(499) == 0) do_reset();
            else cyc(night, $urandom_range(19) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        dchk("queue_drained", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Parametrised two-road intersection controller: the next generation of the board's single-road traffic light demo. One `clk` domain with no derived clocks: internal tick enables drive a six-phase north-south/east-west cycle, a pedestrian green-shortening request, and a night flashing-yellow mode. It drives two RYG lamp sets, a two-digit countdown on active-low seven-segment displays, and a row-scanned 8×8 dot-matrix pictogram.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `clk` cycles per 1 s timing tick; must be ≥ 2.
- `SCAN_DIV`, 5_000: `clk` cycles per dot-matrix row step; must be ≥ 2.
- `GREEN_T`, 10: green duration in ticks; range 1..99.
- `YELLOW_T`, 3: yellow duration in ticks; range 1..99.
- `ALLRED_T`, 1: all-red clearance in ticks; range 1..99.
- `PED_T`, 5: remaining-green cap applied on a pedestrian request; must satisfy 1 ≤ PED_T < GREEN_T.

Ports (direction, width, meaning):
- `clk`: in, 1; the single clock.
- `reset`: in, 1; reset is asynchronous and active-high.
- `night_mode`: in, 1; request flashing-yellow mode. Level, synchronous to `clk`.
- `ped_req`: in, 1; pedestrian button. Synchronous to `clk`; any high cycle counts.
- `ns_light`: out, 3; north-south lamps {red, yellow, green}, active-high.
- `ew_light`: out, 3; east-west lamps {red, yellow, green}, active-high.
- `phase`: out, 3; current FSM state encoding.
- `seg_tens`: out, 7; tens digit, active-low, gfedcba order.
- `seg_ones`: out, 7; ones digit, active-low, gfedcba order.
- `dot_row`: out, 8; row select, active-low; bit 7 is row 0.
- `dot_column`: out, 8; column data for the selected row, active-high.

## Operation
- **Tick generators**
  - `tcnt` counts 0..TICK_DIV-1 and wraps. `tick` is high for the one cycle where `tcnt == TICK_DIV-1`.
  - `scnt` counts 0..SCAN_DIV-1 and wraps. `stick` is high for the one cycle where `scnt == SCAN_DIV-1`.
  - Both counters are free-running and independent.
- **FSM states**: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, FLASH=6. Code 7 is illegal and recovers to NS_G on the next `clk`.
- **Counter**: `remain` is 7 bits. On entry to a state it loads that state's duration (G=GREEN_T, Y=YELLOW_T, AR=ALLRED_T).
  - On a `tick` with `remain == 1`, the FSM advances to the next state.
  - Otherwise, on a `tick`, `remain` decrements by 1. Each state therefore lasts exactly its duration in ticks.
  - Sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G.
- **Pedestrian request**
  - `ped_req` high sets `ped_pending`. The flag is held through non-green states.
  - On a `tick` in NS_G or EW_G with `ped_pending` set:
    - if `remain > PED_T`, load `remain = PED_T` (no decrement that tick);
    - else apply the normal decrement/advance.
    - In either case, clear `ped_pending`.
  - `ped_req` high on the same cycle as a clearing tick leaves `ped_pending` set (set wins).
- **Night mode**
  - On the `tick` that would exit AR1 or AR2, if `night_mode = 1`, go to FLASH instead of the next green.
  - In FLASH, `blink` loads 1 on entry and toggles every tick.
  - On a FLASH `tick` with `night_mode = 0`, go to AR1 with `remain = ALLRED_T`. The normal cycle then resumes at EW_G.
  - `night_mode` is ignored in every other state. `ped_pending` is held in FLASH.
- **Lamps** (combinational from state and `blink`)
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - AR1/AR2: both 100.
  - FLASH: both `{0, blink, 0}`.
- **Seven-segment**
  - Tens digit is `remain / 10`; ones digit is `remain % 10`.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A tens digit of 0 is blanked (1111111).
  - In FLASH, both digits are blank.
- **Dot matrix**
  - `row_idx` (3 bits) increments on `stick` and wraps 7→0.
  - On `stick`, `dot_row` registers `~(8'h80 >> row_idx)` and `dot_column` registers glyph[row_idx].
  - Glyph ROMs, rows 0..7:
    - GO: 30,30,98,7E,19,18,14,12 (hex).
    - CAUTION: 00,24,3C,BD,FF,3C,3C,00.
    - STOP: 18,18,3C,3C,5A,18,18,24.
  - Glyph selection: greens → GO; yellows → CAUTION; AR1/AR2 → STOP; FLASH → CAUTION when `blink = 1`, else columns 00.

## Timing
- **Reset values** (asynchronous `reset` high)
  - state NS_G, `remain = GREEN_T`, `tcnt = scnt = 0`, `row_idx = 0`.
  - `ped_pending = 0`, `blink = 0`.
  - `dot_row = FF`, `dot_column = 00`.
  - Consequently `ns_light = 001`, `ew_light = 100`, and the segments show GREEN_T.
- **Reset mid-operation** (any state, including FLASH): returns to the reset values immediately. No residual `ped_pending`.
- **Tick timing**: the first `tick` occurs on the TICK_DIV-th rising edge after `reset` falls. State and `remain` update on the `clk` edge where `tick = 1`.
- **Output latency**: lamps, `phase` and segments follow state combinationally (zero added latency). The dot outputs lag `stick` by one `clk` (registered).
- **Simultaneous `tick` and `stick`**: independent; both take effect on the same edge. The glyph selection uses the pre-edge state.

## Test plan
Bench settings: TICK_DIV=4, SCAN_DIV=2, defaults otherwise.
- **Full cycle**: reset, then 28 ticks.
  - Phases: NS_G×10, NS_Y×3, AR1×1, EW_G×10, EW_Y×3, AR2×1.
  - Then back to NS_G with `remain = 10`, `seg_tens = 1111001`, `seg_ones = 1000000`.
- **Pedestrian shortening**: pulse `ped_req` for 1 cycle in NS_G at `remain = 9`. Next tick → `remain = 5`; NS_Y is entered 5 ticks later.
- **Late pedestrian request**: pulse `ped_req` in EW_G at `remain = 3`. Next tick → `remain = 2`, `ped_pending = 0`; the cycle is otherwise unchanged.
- **Night mode entry and exit**: assert `night_mode` during EW_G.
  - The FSM finishes EW_Y and AR2, then enters FLASH.
  - In FLASH: `ns_light = ew_light = 010`/`000`, alternating each tick; both segments read 1111111.
  - Deassert `night_mode` → AR1 for 1 tick → EW_G with `remain = 10`.
- **Reset during FLASH**: `reset` pulse → NS_G, `remain = 10`, `dot_row = FF`, `dot_column = 00`, asynchronously (before the next `clk`).
- **Dot-matrix scan**: hold in AR1 with a large ALLRED_T.
  - `dot_row` cycles 7F,BF,DF,EF,F7,FB,FD,FE, one value per 2 clk.
  - `dot_column` cycles 18,18,3C,3C,5A,18,18,24, aligned with `dot_row`.
